decode_output_queue: RTL and testbench
======================================

DECODE_OUTPUT_QUEUE -- requirements
Module: decode_output_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter RD_W, default 6, width of reg_rd_id fields.
REQ-003 Parameter RS_W, default 5, width of rs1_id/rs2_id fields.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  decode entry offered.
REQ-007 in_ready  output  1  queue accepts entry this cycle.
REQ-008 in_reg_rd_id / in_rs1_id / in_rs2_id  input  RD_W / RS_W / RS_W  register ids of offered entry.
REQ-009 in_resolve, in_select_target_pc, in_squash_after_J, in_squash_after_JALR  input  1 each  control flags of offered entry.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_ready  input  1  consumer takes head entry.
REQ-012 out_reg_rd_id, out_rs1_id, out_rs2_id, out_resolve, out_select_target_pc, out_squash_after_J, out_squash_after_JALR  output  same widths as inputs  head entry fields.
REQ-013 flush  input  1  discard all queued entries.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (count < DEPTH), independent of out_ready; no push when full even with simultaneous pop.
REQ-017 out_valid SHALL equal (count != 0); out_* fields SHALL present the oldest entry from registered storage, all-zero when empty.
REQ-018 Latency: a pushed entry SHALL appear on out_* with out_valid=1 in the cycle after the push edge; no combinational in-to-out path.
REQ-019 Entries SHALL leave in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and keep ordering.
REQ-021 count SHALL increment on push-only, decrement on pop-only, never exceed DEPTH nor underflow.
REQ-022 in_valid while full SHALL be held off (no overwrite); out_ready while empty SHALL have no effect.
REQ-023 flush SHALL take priority: at that edge count and pointers SHALL go to 0; a same-cycle push and pop SHALL both be discarded.
REQ-024 Offered fields SHALL be stored unmodified; flags SHALL not be interpreted except per REQ-030.

Reset
REQ-025 While rst_n=0: count=0, pointers=0, out_valid=0, all out_* fields=0, storage cleared to 0.
REQ-026 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for clk.

Configuration
REQ-028 Macro DECODE_OUTQ_AUTOSQUASH_EN selects automatic squash.
REQ-029 Without macro: entries leave only by pop or flush/reset.
REQ-030 With macro: a pop whose head has out_squash_after_J=1 or out_squash_after_JALR=1 SHALL discard all younger entries and any same-cycle push at that edge; count=0 next cycle.

Verification
REQ-031 Reset, push rd=5,rs1=1,rs2=2 -> next cycle out_valid=1, out_reg_rd_id=5, out_rs1_id=1, out_rs2_id=2, count=1.
REQ-032 DEPTH=4, out_ready=0, push rd=1..5 -> in_ready=0 after 4th push, count=4, 5th held; then pop 4 -> rd 1,2,3,4 in order.
REQ-033 count=2, continuous push and pop 10 cycles -> count stays 2, pointers wrap, outputs in push order.
REQ-034 count=3, flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-035 Macro on: queue rd=1 (squash_after_J=1), rd=2, rd=3, pop rd=1 -> next cycle count=0; macro off: same stimulus -> count=2, head rd=2.
REQ-036 count=2, rst_n low mid-cycle -> out_valid=0 and count=0 before next clk edge.

Source files
------------

// File: rtl/decode_output_queue.sv
// In-order FIFO between decode and issue, holding register ids and control flags per entry.
// Optional macro DECODE_OUTQ_AUTOSQUASH_EN: popping a squash-after-J/JALR head also drops all younger entries.

module decode_outq_slot #(
  parameter int EW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata
);
  logic [EW-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (we) data_d = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign rdata = data_q;
endmodule

module decode_output_queue #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 6,
  parameter int RS_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RD_W-1:0]          in_reg_rd_id,
  input  logic [RS_W-1:0]          in_rs1_id,
  input  logic [RS_W-1:0]          in_rs2_id,
  input  logic                     in_resolve,
  input  logic                     in_select_target_pc,
  input  logic                     in_squash_after_J,
  input  logic                     in_squash_after_JALR,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RD_W-1:0]          out_reg_rd_id,
  output logic [RS_W-1:0]          out_rs1_id,
  output logic [RS_W-1:0]          out_rs2_id,
  output logic                     out_resolve,
  output logic                     out_select_target_pc,
  output logic                     out_squash_after_J,
  output logic                     out_squash_after_JALR,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = RD_W + 2*RS_W + 4;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [RS_W-1:0] rs1;
    logic [RS_W-1:0] rs2;
    logic            resolve;
    logic            sel_tpc;
    logic            sq_j;
    logic            sq_jalr;
  } entry_t;

  entry_t                   in_ent, head;
  logic [DEPTH-1:0][EW-1:0] slot_q;
  logic [DEPTH-1:0]         slot_we;
  logic [PW-1:0]            wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]            count_d, count_q;
  logic                     push, pop, squash;

  assign in_ent = {in_reg_rd_id, in_rs1_id, in_rs2_id, in_resolve,
                   in_select_target_pc, in_squash_after_J, in_squash_after_JALR};

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Head comes straight from storage; masked so an empty queue shows all-zero fields.
  assign head = out_valid ? entry_t'(slot_q[rd_ptr_q]) : '0;

`ifdef DECODE_OUTQ_AUTOSQUASH_EN
  assign squash = pop && (head.sq_j || head.sq_jalr);
`else
  assign squash = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    slot_we  = '0;
    if (flush || squash) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        slot_we[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    decode_outq_slot #(.EW(EW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (slot_we[gi]),
      .wdata (in_ent),
      .rdata (slot_q[gi])
    );
  end

  assign out_reg_rd_id         = head.rd;
  assign out_rs1_id            = head.rs1;
  assign out_rs2_id            = head.rs2;
  assign out_resolve           = head.resolve;
  assign out_select_target_pc  = head.sel_tpc;
  assign out_squash_after_J    = head.sq_j;
  assign out_squash_after_JALR = head.sq_jalr;
endmodule

// File: tb/tb_decode_output_queue.sv
// Directed bench for decode_output_queue: vector table plus hand sequences for reset and squash corners.

module tb_decode_output_queue;
  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [5:0] in_reg_rd_id;
  logic [4:0] in_rs1_id, in_rs2_id;
  logic       in_resolve, in_select_target_pc, in_squash_after_J, in_squash_after_JALR;
  logic       out_valid, out_ready;
  logic [5:0] out_reg_rd_id;
  logic [4:0] out_rs1_id, out_rs2_id;
  logic       out_resolve, out_select_target_pc, out_squash_after_J, out_squash_after_JALR;
  logic       flush;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  decode_output_queue #(.DEPTH(4), .RD_W(6), .RS_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_rd_id(in_reg_rd_id), .in_rs1_id(in_rs1_id), .in_rs2_id(in_rs2_id),
    .in_resolve(in_resolve), .in_select_target_pc(in_select_target_pc),
    .in_squash_after_J(in_squash_after_J), .in_squash_after_JALR(in_squash_after_JALR),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_rd_id(out_reg_rd_id), .out_rs1_id(out_rs1_id), .out_rs2_id(out_rs2_id),
    .out_resolve(out_resolve), .out_select_target_pc(out_select_target_pc),
    .out_squash_after_J(out_squash_after_J), .out_squash_after_JALR(out_squash_after_JALR),
    .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [5:0] rd;
    logic       sqj;
    logic       ordy;
    logic       fl;
    int         ecnt;
    logic       eov;
    logic [5:0] erd;
  } vec_t;

  vec_t tbl[$];

  // Field patterns derived from rd so every stored field is distinct per entry.
  function automatic logic [4:0] f1(input logic [5:0] r);
    return r[4:0] ^ 5'h0A;
  endfunction
  function automatic logic [4:0] f2(input logic [5:0] r);
    return r[4:0] + 5'd3;
  endfunction
  function automatic logic [17:0] head_of(input logic [5:0] r);
    if (r == 6'd0) return 18'd0;
    return {r, f1(r), f2(r), r[0], r[1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [5:0] rd, input logic sqj, input logic ordy,
                     input logic fl, input int ecnt, input logic [5:0] erd);
    vec_t v;
    v.iv = iv; v.rd = rd; v.sqj = sqj; v.ordy = ordy; v.fl = fl;
    v.ecnt = ecnt; v.eov = (ecnt != 0); v.erd = erd;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [5:0] rd, input logic sqj,
                       input logic ordy, input logic fl);
    in_valid = iv; in_reg_rd_id = rd; in_rs1_id = f1(rd); in_rs2_id = f2(rd);
    in_resolve = rd[0]; in_select_target_pc = rd[1];
    in_squash_after_J = sqj; in_squash_after_JALR = 1'b0;
    out_ready = ordy; flush = fl;
  endtask

  initial begin
    drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_head", 32'({out_reg_rd_id, out_rs1_id, out_rs2_id, out_resolve,
                         out_select_target_pc, out_squash_after_J, out_squash_after_JALR}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Exact field values from the first-push example.
    in_valid = 1'b1; in_reg_rd_id = 6'd5; in_rs1_id = 5'd1; in_rs2_id = 5'd2;
    in_resolve = 1'b0; in_select_target_pc = 1'b0;
    @(posedge clk); #1;
    chk("first_push_valid", 32'(out_valid), 32'd1);
    chk("first_push_fields", 32'({out_reg_rd_id, out_rs1_id, out_rs2_id}), 32'({6'd5, 5'd1, 5'd2}));
    chk("first_push_count", 32'(count), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("first_pop_count", 32'(count), 32'd0);

    // Fill to full, offer a fifth, then pop with push blocked while full.
    add(1, 1, 0, 0, 0, 1, 1);
    add(1, 2, 0, 0, 0, 2, 1);
    add(1, 3, 0, 0, 0, 3, 1);
    add(1, 4, 0, 0, 0, 4, 1);
    add(1, 5, 0, 0, 0, 4, 1);
    add(1, 6, 0, 1, 0, 3, 2);
    add(0, 0, 0, 1, 0, 2, 3);
    add(0, 0, 0, 1, 0, 1, 4);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    // Reach count 2, then ten cycles of push+pop across pointer wraps.
    add(1, 7, 0, 0, 0, 1, 7);
    add(1, 8, 0, 0, 0, 2, 7);
    for (int k = 9; k <= 18; k++) add(1, 6'(k), 0, 1, 0, 2, 6'(k - 1));
    // Count 3, then flush with a simultaneous push and pop.
    add(1, 19, 0, 0, 0, 3, 17);
    add(1, 20, 0, 1, 1, 0, 0);
    add(1, 21, 0, 0, 0, 1, 21);
    add(0, 0, 0, 1, 0, 0, 0);
    // Head with squash_after_J popped while two younger entries wait.
    add(1, 1, 1, 0, 0, 1, 1);
    add(1, 2, 0, 0, 0, 2, 1);
    add(1, 3, 0, 0, 0, 3, 1);
`ifdef DECODE_OUTQ_AUTOSQUASH_EN
    add(0, 0, 0, 1, 0, 0, 0);
`else
    add(0, 0, 0, 1, 0, 2, 2);
`endif
    add(0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].rd, tbl[i].sqj, tbl[i].ordy, tbl[i].fl);
      @(posedge clk); #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ecnt < 4));
      chk($sformatf("v%0d_head", i),
          32'({out_reg_rd_id, out_rs1_id, out_rs2_id, out_resolve, out_select_target_pc}),
          32'(head_of(tbl[i].erd)));
    end

    // Squash flag field is carried through unchanged.
    drive(1'b1, 6'd9, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("sqj_stored", 32'(out_squash_after_J), 32'd1);
    chk("sqjalr_stored", 32'(out_squash_after_JALR), 32'd0);

    // Asynchronous reset mid-cycle with two entries queued.
    drive(1'b1, 6'd10, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_arst_count", 32'(count), 32'd2);
    drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_rd", 32'(out_reg_rd_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_arst_in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
